avalon_st_pattern_source: RTL

- Avalon-ST packet transmitter: generates 24-bit {R,G,B} video frames, one frame per packet, with startofpacket/endofpacket framing.
- Honours downstream `out_ready` with ready latency 0.
- Drives the input side of the streaming timing adapters in the video path; used for bring-up and as a known-good source for sink verification.
- A frame is H_ACTIVE×V_ACTIVE beats in raster order; consecutive frames are separated by a programmable idle gap.

---
 rtl/avalon_st_pattern_source.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/avalon_st_pattern_source.sv
// ----------------------------------------------------------------------------
// avalon_st_pattern_source
//
// Avalon-ST video test-pattern transmitter. It emits one packet per frame of
// H_ACTIVE x V_ACTIVE 24-bit {R,G,B} beats in raster order. Each packet is
// framed with startofpacket/endofpacket. Consecutive frames are separated by
// IFG_CYCLES idle cycles. The source honours out_ready with a ready latency
// of 0. All outputs are registered.
//
// Ports:
//   clk                in   clock
//   reset_n            in   asynchronous active-low reset
//   enable             in   1 = generate frames continuously
//   pattern_sel[1:0]   in   0 bars, 1 ramp, 2 solid, 3 checker (or PRBS)
//   solid_color[23:0]  in   colour used by pattern 2
//   out_ready          in   sink ready
//   out_valid          out  beat valid
//   out_data[23:0]     out  pixel {R,G,B}
//   out_startofpacket  out  first pixel of frame
//   out_endofpacket    out  last pixel of frame
//   busy               out  frame in progress
//   frame_count[15:0]  out  frames whose EOP was accepted (wraps)
//
// Build option:
//   AVALON_ST_PATTERN_SOURCE_PRBS_EN - when defined, pattern 3 emits a 24-bit
//   Fibonacci LFSR (x^24+x^23+x^22+x^17+1). The LFSR is seeded with 1 at
//   every SOP and steps once per accepted beat. When the macro is undefined,
//   pattern 3 is an 8x8 checkerboard and no LFSR is built.
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | no frame; start a frame as soon as enable is high
//   ST_ACTIVE | presenting beats of the current frame (out_valid = 1)
//   ST_GAP    | inter-frame idle; gap_cnt counts down to the start decision
// ----------------------------------------------------------------------------
module avalon_st_pattern_source #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int IFG_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_color,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [23:0] out_data,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic        busy,
    output logic [15:0] frame_count
);

    // Lines narrower than 8 pixels get 1-pixel bars; the bar index saturates at 7.
    localparam int BW_RAW = H_ACTIVE / 8;
    localparam int BAR_W  = (BW_RAW < 1) ? 1 : BW_RAW;

    localparam logic [11:0] X_LAST     = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_LAST     = 12'(V_ACTIVE - 1);
    localparam logic [11:0] BAR_RELOAD = 12'(BAR_W - 1);
    localparam logic [15:0] GAP_RELOAD = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    state_t      state_q,   state_d;
    logic [11:0] x_q,       x_d;
    logic [11:0] y_q,       y_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [11:0] bar_cnt_q, bar_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]  pat_q,     pat_d;
    logic [23:0] solid_q,   solid_d;
    logic        valid_q,   valid_d;
    logic [23:0] data_q,    data_d;
    logic        sop_q,     sop_d;
    logic        eop_q,     eop_d;
    logic        busy_q,    busy_d;
    logic [15:0] fcnt_q,    fcnt_d;
`ifdef AVALON_ST_PATTERN_SOURCE_PRBS_EN
    logic [23:0] lfsr_q,    lfsr_d;
`endif

    logic accept;
    logic start;
    logic step;

    assign accept = valid_q && out_ready;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_idx_d = bar_idx_q;
        bar_cnt_d = bar_cnt_q;
        gap_cnt_d = gap_cnt_q;
        pat_d     = pat_q;
        solid_d   = solid_q;
        valid_d   = valid_q;
        data_d    = data_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        fcnt_d    = fcnt_q;
        start     = 1'b0;
        step      = 1'b0;
`ifdef AVALON_ST_PATTERN_SOURCE_PRBS_EN
        lfsr_d    = lfsr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    start = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (accept) begin
                    if (eop_q) begin
                        fcnt_d = fcnt_q + 16'd1;
                        if (IFG_CYCLES == 0) begin
                            if (enable) begin
                                start = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                valid_d = 1'b0;
                                sop_d   = 1'b0;
                                eop_d   = 1'b0;
                            end
                        end else begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_RELOAD;
                            valid_d   = 1'b0;
                            sop_d     = 1'b0;
                            eop_d     = 1'b0;
                        end
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
            end
        endcase

        // New frame: latch the pattern controls and present pixel (0,0).
        if (start) begin
            state_d   = ST_ACTIVE;
            pat_d     = pattern_sel;
            solid_d   = solid_color;
            x_d       = 12'd0;
            y_d       = 12'd0;
            bar_idx_d = 3'd0;
            bar_cnt_d = BAR_RELOAD;
            valid_d   = 1'b1;
            sop_d     = 1'b1;
            eop_d     = 1'b0;
`ifdef AVALON_ST_PATTERN_SOURCE_PRBS_EN
            lfsr_d    = 24'h000001;
`endif
        end

        // Accepted non-final beat: move to the next raster coordinate.
        if (step) begin
            if (x_q == X_LAST) begin
                x_d       = 12'd0;
                y_d       = y_q + 12'd1;
                bar_idx_d = 3'd0;
                bar_cnt_d = BAR_RELOAD;
            end else begin
                x_d = x_q + 12'd1;
                if (bar_cnt_q != 12'd0) begin
                    bar_cnt_d = bar_cnt_q - 12'd1;
                end else if (bar_idx_q != 3'd7) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                    bar_cnt_d = BAR_RELOAD;
                end
            end
            sop_d = 1'b0;
            eop_d = (x_d == X_LAST) && (y_d == Y_LAST);
`ifdef AVALON_ST_PATTERN_SOURCE_PRBS_EN
            lfsr_d = {lfsr_q[22:0], lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16]};
`endif
        end

        // The pixel is computed for the beat about to be presented, so
        // out_data stays registered and holds through stalls.
        if (start || step) begin
            case (pat_d)
                2'd0: begin
                    case (bar_idx_d)
                        3'd0:    data_d = 24'hFFFFFF;
                        3'd1:    data_d = 24'hFFFF00;
                        3'd2:    data_d = 24'h00FFFF;
                        3'd3:    data_d = 24'h00FF00;
                        3'd4:    data_d = 24'hFF00FF;
                        3'd5:    data_d = 24'hFF0000;
                        3'd6:    data_d = 24'h0000FF;
                        default: data_d = 24'h000000;
                    endcase
                end
                2'd1:    data_d = {x_d, y_d};
                2'd2:    data_d = solid_d;
                default: begin
`ifdef AVALON_ST_PATTERN_SOURCE_PRBS_EN
                    data_d = lfsr_d;
`else
                    data_d = (x_d[3] ^ y_d[3]) ? 24'hFFFFFF : 24'h000000;
`endif
                end
            endcase
        end

        busy_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            x_q       <= 12'd0;
            y_q       <= 12'd0;
            bar_idx_q <= 3'd0;
            bar_cnt_q <= 12'd0;
            gap_cnt_q <= 16'd0;
            pat_q     <= 2'd0;
            solid_q   <= 24'd0;
            valid_q   <= 1'b0;
            data_q    <= 24'd0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            busy_q    <= 1'b0;
            fcnt_q    <= 16'd0;
`ifdef AVALON_ST_PATTERN_SOURCE_PRBS_EN
            lfsr_q    <= 24'h000001;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_idx_q <= bar_idx_d;
            bar_cnt_q <= bar_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            pat_q     <= pat_d;
            solid_q   <= solid_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            busy_q    <= busy_d;
            fcnt_q    <= fcnt_d;
`ifdef AVALON_ST_PATTERN_SOURCE_PRBS_EN
            lfsr_q    <= lfsr_d;
`endif
        end
    end

    assign out_valid         = valid_q;
    assign out_data          = data_q;
    assign out_startofpacket = sop_q;
    assign out_endofpacket   = eop_q;
    assign busy              = busy_q;
    assign frame_count       = fcnt_q;

endmodule
